// File: rtl/send_pkt_preamble_arb.sv
// Round-robin arbiter in front of a USB packet sender. Grants one channel at
// a time and, for low-speed devices behind a hub, brackets the real PID with a
// full-speed preamble token, a hub setup gap and the line-control overrides.
module send_pkt_preamble_arb #(
  parameter int          NUM_CH     = 2,
  parameter int          GAP_CYCLES = 4,
  parameter int          TIMEOUT    = 1023,
  parameter logic [3:0]  PRE_PID    = 4'b1100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [4*NUM_CH-1:0]   req_pid,
  input  logic [NUM_CH-1:0]     req_pream,
  output logic [NUM_CH-1:0]     req_ack,
  output logic [NUM_CH-1:0]     req_done,
  output logic [NUM_CH-1:0]     req_err,
  output logic                  spk_wen,
  output logic [3:0]            spk_pid,
  input  logic                  spk_rdy,
  output logic                  fs_bit_rate,
  output logic                  fs_polarity,
  output logic                  grab_line,
  output logic                  busy
);

  localparam int CW = (NUM_CH > 1)     ? $clog2(NUM_CH)         : 1;
  localparam int TW = (TIMEOUT > 0)    ? $clog2(TIMEOUT + 1)    : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, ARB, P_WAIT1, P_PRE, P_WAIT2, P_GAP, P_PID, P_WAIT3,
    R_WAIT1, R_PID, R_WAIT2
  } state_t;

  state_t          state, stateN;
  logic [CW-1:0]   rrPtr, rrPtrN, grant, grantN, arbIdx;
  logic [3:0]      pidQ, pidQN, spkPidN;
  logic            preamQ, preamQN;
  logic [TW-1:0]   toCnt, toCntN;
  logic [GW-1:0]   gapCnt, gapCntN;
  logic            wenDly, found, rdyOk, toHit, isWait;
  logic            spkWenN, fsrN, fspN, grabN, busyN;
  logic [NUM_CH-1:0] ackN, doneN, errN;

  // Round-robin search: first valid channel at or after rrPtr, wrapping.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    arbIdx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rrPtr) + k) % NUM_CH;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        arbIdx = CW'(idx);
      end
    end
  end

  // The sender's ready lags its write strobe by a cycle, so ready seen right
  // after a strobe is stale and must not advance the FSM.
  assign rdyOk  = spk_rdy & ~wenDly;
  assign toHit  = (TIMEOUT != 0) && (toCnt == TW'(TIMEOUT - 1));
  assign isWait = (state == P_WAIT1) || (state == P_WAIT2) || (state == P_WAIT3) ||
                  (state == R_WAIT1) || (state == R_WAIT2);

  // Next-state and next-output logic; every output is registered, so strobes
  // are raised on the transition into the state that owns them.
  always_comb begin
    stateN  = state;
    rrPtrN  = rrPtr;
    grantN  = grant;
    pidQN   = pidQ;
    preamQN = preamQ;
    toCntN  = toCnt;
    gapCntN = gapCnt;
    spkWenN = 1'b0;
    spkPidN = spk_pid;
    fsrN    = fs_bit_rate;
    fspN    = fs_polarity;
    grabN   = grab_line;
    ackN    = '0;
    doneN   = '0;
    errN    = '0;
    case (state)
      IDLE: if (|req_valid) stateN = ARB;
      ARB: begin
        if (found) begin
          ackN    = NUM_CH'(1) << arbIdx;
          grantN  = arbIdx;
          pidQN   = req_pid[int'(arbIdx)*4 +: 4];
          preamQN = req_pream[arbIdx];
          toCntN  = '0;
          stateN  = req_pream[arbIdx] ? P_WAIT1 : R_WAIT1;
        end else begin
          stateN = IDLE;
        end
      end
      P_WAIT1: if (rdyOk) begin
        fsrN = 1'b1; fspN = 1'b1; grabN = 1'b1;
        spkWenN = 1'b1; spkPidN = PRE_PID;
        stateN  = P_PRE;
      end
      P_PRE: begin
        toCntN = '0;
        stateN = P_WAIT2;
      end
      P_WAIT2: if (rdyOk) begin
        fsrN = 1'b0; fspN = 1'b0;
        gapCntN = '0;
        if (GAP_CYCLES == 0) begin
          spkWenN = 1'b1; spkPidN = pidQ;
          stateN  = P_PID;
        end else begin
          stateN = P_GAP;
        end
      end
      P_GAP: begin
        if (gapCnt == GW'(GAP_CYCLES - 1)) begin
          spkWenN = 1'b1; spkPidN = pidQ;
          stateN  = P_PID;
        end else begin
          gapCntN = gapCnt + 1'b1;
        end
      end
      P_PID: begin
        toCntN = '0;
        stateN = P_WAIT3;
      end
      P_WAIT3: if (rdyOk) begin
        grabN = 1'b0; fsrN = 1'b1; fspN = 1'b1;
        doneN  = NUM_CH'(1) << grant;
        rrPtrN = CW'((int'(grant) + 1) % NUM_CH);
        stateN = IDLE;
      end
      R_WAIT1: if (rdyOk) begin
        spkWenN = 1'b1; spkPidN = pidQ;
        stateN  = R_PID;
      end
      R_PID: begin
        toCntN = '0;
        stateN = R_WAIT2;
      end
      R_WAIT2: if (rdyOk) begin
        doneN  = NUM_CH'(1) << grant;
        rrPtrN = CW'((int'(grant) + 1) % NUM_CH);
        stateN = IDLE;
      end
      default: stateN = IDLE;
    endcase
    // Shared timeout path for all wait states while the sender stays busy.
    if (isWait && !rdyOk) begin
      if (toHit) begin
        grabN = 1'b0; fsrN = 1'b1; fspN = 1'b1;
        errN   = NUM_CH'(1) << grant;
        rrPtrN = CW'((int'(grant) + 1) % NUM_CH);
        stateN = IDLE;
      end else if (TIMEOUT != 0) begin
        toCntN = toCnt + 1'b1;
      end
    end
    busyN = (stateN != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rrPtr       <= '0;
      grant       <= '0;
      pidQ        <= '0;
      preamQ      <= 1'b0;
      toCnt       <= '0;
      gapCnt      <= '0;
      wenDly      <= 1'b0;
      spk_wen     <= 1'b0;
      spk_pid     <= '0;
      fs_bit_rate <= 1'b1;
      fs_polarity <= 1'b1;
      grab_line   <= 1'b0;
      req_ack     <= '0;
      req_done    <= '0;
      req_err     <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= stateN;
      rrPtr       <= rrPtrN;
      grant       <= grantN;
      pidQ        <= pidQN;
      preamQ      <= preamQN;
      toCnt       <= toCntN;
      gapCnt      <= gapCntN;
      wenDly      <= spk_wen;
      spk_wen     <= spkWenN;
      spk_pid     <= spkPidN;
      fs_bit_rate <= fsrN;
      fs_polarity <= fspN;
      grab_line   <= grabN;
      req_ack     <= ackN;
      req_done    <= doneN;
      req_err     <= errN;
      busy        <= busyN;
    end
  end

endmodule

// File: tb/tb_send_pkt_preamble_arb.sv
// Scoreboard bench: stimulus pushes expected events (ack, write strobe,
// done, err) into a queue; a negedge monitor pops and compares each event the
// DUT produces, including the line-control state at that moment.
module tb_send_pkt_preamble_arb;

  localparam int NCH = 2;
  localparam logic [3:0] PRE = 4'b1100;

  logic           clk = 0;
  logic           rst;
  logic [NCH-1:0] req_valid, req_pream, req_ack, req_done, req_err;
  logic [4*NCH-1:0] req_pid;
  logic           spk_wen, spk_rdy, fs_bit_rate, fs_polarity, grab_line, busy;
  logic [3:0]     spk_pid;

  send_pkt_preamble_arb #(.NUM_CH(NCH), .GAP_CYCLES(4), .TIMEOUT(16), .PRE_PID(PRE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pid(req_pid),
    .req_pream(req_pream), .req_ack(req_ack), .req_done(req_done),
    .req_err(req_err), .spk_wen(spk_wen), .spk_pid(spk_pid), .spk_rdy(spk_rdy),
    .fs_bit_rate(fs_bit_rate), .fs_polarity(fs_polarity),
    .grab_line(grab_line), .busy(busy));

  always #5 clk = ~clk;

  // kind: 0 ack, 1 write strobe, 2 done, 3 err
  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] val;
    logic       grab;
    logic       fsr;
  } ev_t;

  ev_t         expQ[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned wenCyc[$];
  logic        prevWen;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input logic [1:0] k, input logic [3:0] v,
                             input logic g, input logic f);
    ev_t e;
    e.kind = k; e.val = v; e.grab = g; e.fsr = f;
    return e;
  endfunction

  function automatic logic [3:0] chanOf(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return 4'(i);
    return 4'hF;
  endfunction

  task automatic chkEv(input ev_t got, input string name);
    ev_t e;
    tests++;
    if (expQ.size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected event got %h, nothing expected (cycle %0d)", name, got, cyc);
    end else begin
      e = expQ.pop_front();
      if (got !== e) begin
        fails++;
        $display("FAIL %s: got %h expected %h (kind/val/grab/fsr, cycle %0d)", name, got, e, cyc);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every DUT event and checks invariants.
  always @(negedge clk) begin
    if (rst) begin
      prevWen <= 1'b0;
    end else begin
      if (spk_wen || (|{req_ack, req_done, req_err})) begin
        tests++;
        if ((spk_wen && prevWen) || ($countones({req_ack, req_done, req_err}) > 1)) begin
          fails++;
          $display("FAIL invariant: wen %b prev %b ack %b done %b err %b", spk_wen, prevWen,
                   req_ack, req_done, req_err);
        end
      end
      if (|req_ack)  chkEv(mk(2'd0, chanOf(req_ack),  grab_line, fs_bit_rate), "ack");
      if (spk_wen) begin
        wenCyc.push_back(cyc);
        chkEv(mk(2'd1, spk_pid, grab_line, fs_bit_rate), "wen");
      end
      if (|req_done) chkEv(mk(2'd2, chanOf(req_done), grab_line, fs_bit_rate), "done");
      if (|req_err)  chkEv(mk(2'd3, chanOf(req_err),  grab_line, fs_bit_rate), "err");
      prevWen <= spk_wen;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic checkReset(input string name);
    logic [14:0] got;
    got = {spk_wen, spk_pid, fs_bit_rate, fs_polarity, grab_line, req_ack, req_done, req_err, busy};
    tests++;
    if (got !== 15'b0_0000_1_1_0_00_00_00_0) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, 15'b0_0000_1_1_0_00_00_00_0);
    end
  endtask

  task automatic setCh(input int ch, input logic [3:0] pid, input logic pream);
    req_pid[ch*4 +: 4] = pid;
    req_pream[ch] = pream;
  endtask

  task automatic waitAck(input int ch);
    int n = 0;
    do begin @(negedge clk); n++; end while (!req_ack[ch] && n < 100);
    if (!req_ack[ch]) begin fails++; tests++; $display("FAIL ack_timeout: ch %0d no ack", ch); end
  endtask

  task automatic waitWen();
    int n = 0;
    do begin @(negedge clk); n++; end while (!spk_wen && n < 100);
    if (!spk_wen) begin fails++; tests++; $display("FAIL wen_timeout: no strobe"); end
  endtask

  task automatic waitEnd(input int ch);
    int n = 0;
    do begin @(negedge clk); n++; end while (!req_done[ch] && !req_err[ch] && n < 200);
    if (!req_done[ch] && !req_err[ch]) begin
      fails++; tests++; $display("FAIL end_timeout: ch %0d never finished", ch);
    end
  endtask

  task automatic sendOne(input int ch, input logic [3:0] pid, input logic pream);
    expQ.push_back(mk(2'd0, 4'(ch), 1'b0, 1'b1));
    if (pream) begin
      expQ.push_back(mk(2'd1, PRE, 1'b1, 1'b1));
      expQ.push_back(mk(2'd1, pid, 1'b1, 1'b0));
    end else begin
      expQ.push_back(mk(2'd1, pid, 1'b0, 1'b1));
    end
    expQ.push_back(mk(2'd2, 4'(ch), 1'b0, 1'b1));
    setCh(ch, pid, pream);
    req_valid[ch] = 1'b1;
    waitAck(ch);
    req_valid[ch] = 1'b0;
    req_pid[ch*4 +: 4] = ~pid;   // must not leak into the packet in flight
    waitEnd(ch);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int unsigned tPre, acks, n;
    rst = 1; req_valid = '0; req_pid = '0; req_pream = '0; spk_rdy = 1;
    repeat (3) @(negedge clk);
    checkReset("reset_init");
    rst = 0;
    repeat (2) @(negedge clk);

    // Plain packet, no preamble.
    sendOne(0, 4'b1001, 1'b0);

    // Preamble packet: PRE strobe to PID strobe spans 1 stale-ready cycle,
    // 1 accept cycle, 4 gap cycles and the PID cycle.
    wenCyc.delete();
    sendOne(1, 4'b0001, 1'b1);
    check("gap_span", (wenCyc.size() == 2) ? int'(wenCyc[1] - wenCyc[0]) : -1, 7);

    // Two channels held valid: grants alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(mk(2'd0, 4'(i % 2), 1'b0, 1'b1));
      expQ.push_back(mk(2'd1, (i % 2) ? 4'h5 : 4'h3, 1'b0, 1'b1));
      expQ.push_back(mk(2'd2, 4'(i % 2), 1'b0, 1'b1));
    end
    setCh(0, 4'h3, 1'b0);
    setCh(1, 4'h5, 1'b0);
    req_valid = 2'b11;
    acks = 0; n = 0;
    while (acks < 4 && n < 400) begin
      @(negedge clk); n++;
      if (|req_ack) acks++;
    end
    check("rr_acks", int'(acks), 4);
    req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 100);
    check("rr_idle", int'(busy), 0);
    repeat (2) @(negedge clk);

    // Timeout in P_WAIT2: err 16 cycles after entry (PRE strobe + 1).
    expQ.push_back(mk(2'd0, 4'd0, 1'b0, 1'b1));
    expQ.push_back(mk(2'd1, PRE, 1'b1, 1'b1));
    expQ.push_back(mk(2'd3, 4'd0, 1'b0, 1'b1));
    setCh(0, 4'h7, 1'b1);
    req_valid[0] = 1'b1;
    waitAck(0);
    req_valid[0] = 1'b0;
    waitWen();
    tPre = cyc;
    spk_rdy = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_err[0] && n < 100);
    check("timeout_latency", int'(cyc - tPre), 17);
    check("timeout_lines", int'({grab_line, fs_bit_rate, fs_polarity, busy}), 4'b0110);
    spk_rdy = 1;
    repeat (3) @(negedge clk);

    // Reset during P_GAP: no done/err, outputs back to reset values,
    // then the still-held request completes normally.
    expQ.push_back(mk(2'd0, 4'd1, 1'b0, 1'b1));
    expQ.push_back(mk(2'd1, PRE, 1'b1, 1'b1));
    setCh(1, 4'b0110, 1'b1);
    req_valid[1] = 1'b1;
    waitAck(1);
    waitWen();
    repeat (3) @(negedge clk);
    check("in_gap_busy", int'({busy, grab_line, fs_bit_rate}), 3'b110);
    rst = 1;
    @(negedge clk);
    checkReset("reset_in_gap");
    rst = 0;
    sendOne(1, 4'b0110, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
